seg_scan_driver: RTL and testbench

//   Display end of the taxi-meter data_gen output bus: takes binary price, decimal-point mask,

---
 rtl/seg_scan_driver_if.sv | 20 ++
 rtl/seg_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Bus between data_gen and the 7-segment scan driver: display request in,
// digit-select and segment pin drive out.
interface seg_scan_driver_if;
   logic [19:0] price;
   logic [5:0]  point;
   logic        seg_en;
   logic        sign;
   logic [5:0]  sel;
   logic [7:0]  seg;

   modport master (
      output price, point, seg_en, sign,
      input  sel, seg
   );

   modport slave (
      input  price, point, seg_en, sign,
      output sel, seg
   );
endinterface

// File: rtl/seg_scan_driver.sv
// 6-digit common-anode 7-segment scan driver with sequential binary-to-BCD conversion,
// leading-zero blanking and a floating minus sign.
module seg_scan_driver #(
   parameter int unsigned CNT_MAX = 49_999
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   seg_scan_driver_if.slave   bus
);

   localparam int unsigned CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
   localparam logic [19:0]   PRICE_MAX = 20'd999_999;

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

   conv_state_t state, state_nxt;
   logic [19:0] bin_q;
   logic [23:0] bcd_q;
   logic [23:0] bcd_adj;
   logic [4:0]  bit_cnt;
   logic [5:0]  pt_q;
   logic        sign_q;

   logic [23:0] buf_bcd;
   logic [5:0]  buf_point;
   logic        buf_sign;

   logic [CW-1:0] cnt;
   logic [2:0]    digit_idx;
   logic [5:0]    sel_q;
   logic [7:0]    seg_q;
   logic [7:0]    code;
   logic [2:0]    top_m;
   logic [2:0]    top_p;
   logic [2:0]    top;

   function automatic logic [7:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 8'hC0;
         4'd1:    glyph = 8'hF9;
         4'd2:    glyph = 8'hA4;
         4'd3:    glyph = 8'hB0;
         4'd4:    glyph = 8'h99;
         4'd5:    glyph = 8'h92;
         4'd6:    glyph = 8'h82;
         4'd7:    glyph = 8'hF8;
         4'd8:    glyph = 8'h80;
         4'd9:    glyph = 8'h90;
         default: glyph = 8'hFF;
      endcase
   endfunction

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = SHIFT;
         SHIFT:   if (bit_cnt == 5'd19) state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Double-dabble: correct each nibble before it is shifted.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < 6; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bin_q     <= '0;
         bcd_q     <= '0;
         bit_cnt   <= '0;
         pt_q      <= '0;
         sign_q    <= 1'b0;
         buf_bcd   <= '0;
         buf_point <= '0;
         buf_sign  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bin_q   <= (bus.price > PRICE_MAX) ? PRICE_MAX : bus.price;
               bcd_q   <= '0;
               bit_cnt <= '0;
               pt_q    <= bus.point;
               sign_q  <= bus.sign;
            end
            SHIFT: begin
               bcd_q   <= {bcd_adj[22:0], bin_q[19]};
               bin_q   <= {bin_q[18:0], 1'b0};
               bit_cnt <= bit_cnt + 5'd1;
            end
            LOAD: begin
               buf_bcd   <= bcd_q;
               buf_point <= pt_q;
               buf_sign  <= sign_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt       <= '0;
         digit_idx <= '0;
      end else if (cnt == CNT_TOP) begin
         cnt       <= '0;
         digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Highest digit that must be lit: most significant nonzero digit or highest dp.
   always_comb begin
      top_m = 3'd0;
      top_p = 3'd0;
      for (int unsigned i = 0; i < 6; i++) begin
         if (buf_bcd[4*i +: 4] != 4'd0) top_m = 3'(i);
         if (buf_point[i])              top_p = 3'(i);
      end
      top = (top_m > top_p) ? top_m : top_p;
   end

   always_comb begin
      code = glyph(buf_bcd[4*digit_idx +: 4]);
      if (digit_idx > top) begin
         if (buf_sign && (top < 3'd5) && (digit_idx == top + 3'd1)) code = 8'hBF;
         else                                                       code = 8'hFF;
      end
      if (buf_point[digit_idx]) code[7] = 1'b0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sel_q <= '1;
         seg_q <= '1;
      end else if (bus.seg_en) begin
         sel_q <= ~(6'd1 << digit_idx);
         seg_q <= code;
      end else begin
         sel_q <= '1;
         seg_q <= '1;
      end
   end

   assign bus.sel = sel_q;
   assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: decimal reference model of the displayed
// digits plus a scan-position model driven by the bench's own edge counter.
module tb_seg_scan_driver;

   localparam int unsigned DWELL = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned ecount = 0;

   logic [7:0] glyph_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   seg_scan_driver_if bus ();

   seg_scan_driver #(.CNT_MAX(49)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Edges seen since reset release; the scan position follows from this alone.
   always @(posedge clk or posedge rst) begin
      if (rst) ecount <= 0;
      else     ecount <= ecount + 1;
   end

   function automatic int unsigned exp_digit(input int unsigned n);
      return ((n - 1) / DWELL) % 6;
   endfunction

   function automatic logic [5:0] exp_sel(input int unsigned n);
      logic [5:0] s;
      s = 6'h3F;
      s[exp_digit(n)] = 1'b0;
      return s;
   endfunction

   function automatic logic [7:0] exp_code(input int unsigned pr, input logic [5:0] pt,
                                          input logic sg, input int unsigned i);
      int unsigned v, t, m, p, top;
      int unsigned d [6];
      logic [7:0] c;
      v = (pr > 999999) ? 999999 : pr;
      t = v;
      for (int k = 0; k < 6; k++) begin
         d[k] = t % 10;
         t = t / 10;
      end
      m = 0;
      p = 0;
      for (int k = 0; k < 6; k++) begin
         if (d[k] != 0) m = k;
         if (pt[k])     p = k;
      end
      top = (m > p) ? m : p;
      if (i > top) c = (sg && top < 5 && i == top + 1) ? 8'hBF : 8'hFF;
      else         c = glyph_tab[d[i]];
      if (pt[i]) c[7] = 1'b0;
      return c;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.price  = 20'd8;
      bus.point  = 6'd0;
      bus.sign   = 1'b0;
      bus.seg_en = 1'b1;
      repeat (3) tick;
      checks++;
      if (bus.sel !== 6'h3F || bus.seg !== 8'hFF) begin
         errors++;
         $display("FAIL reset_state: sel=%h seg=%h expected sel=3f seg=ff", bus.sel, bus.seg);
      end
      @(negedge clk) rst = 1'b0;
      repeat (5) tick;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (bus.sel !== 6'h3F || bus.seg !== 8'hFF) begin
         errors++;
         $display("FAIL reset_mid_shift: sel=%h seg=%h expected sel=3f seg=ff", bus.sel, bus.seg);
      end
      @(negedge clk) rst = 1'b0;
      repeat (22) tick;
      checks++;
      if (bus.sel !== 6'h3E || bus.seg !== 8'hC0) begin
         errors++;
         $display("FAIL reset_pre_load: sel=%h seg=%h expected sel=3e seg=c0", bus.sel, bus.seg);
      end
      tick;
      checks++;
      if (bus.sel !== 6'h3E || bus.seg !== 8'h80) begin
         errors++;
         $display("FAIL reset_first_load: sel=%h seg=%h expected sel=3e seg=80", bus.sel, bus.seg);
      end
   endtask

   typedef struct {
      int unsigned price;
      logic [5:0]  point;
      logic        sign;
   } case_t;

   task automatic test_patterns;
      case_t tab [7];
      int unsigned k;
      logic [7:0] ec;
      logic [5:0] es;
      tab = '{'{1234, 6'b000100, 1'b0}, '{5, 6'b000100, 1'b0}, '{0, 6'b000000, 1'b0},
              '{1234, 6'b000100, 1'b1}, '{123456, 6'b000000, 1'b1},
              '{20'hFFFFF, 6'b000100, 1'b0}, '{0, 6'b100000, 1'b1}};
      foreach (tab[c]) begin
         bus.price = tab[c].price[19:0];
         bus.point = tab[c].point;
         bus.sign  = tab[c].sign;
         repeat (DWELL) tick;
         for (int s = 0; s < 6 * DWELL; s++) begin
            tick;
            k  = exp_digit(ecount);
            es = exp_sel(ecount);
            ec = exp_code(tab[c].price, tab[c].point, tab[c].sign, k);
            checks++;
            if (bus.sel !== es || bus.seg !== ec) begin
               errors++;
               $display("FAIL pattern%0d_d%0d: sel=%h seg=%h expected sel=%h seg=%h",
                        c, k, bus.sel, bus.seg, es, ec);
            end
         end
      end
   endtask

   task automatic test_random;
      int unsigned pr, k;
      logic [5:0] pt, es;
      logic sg;
      logic [7:0] ec;
      for (int it = 0; it < 8; it++) begin
         case ($urandom_range(0, 3))
            0:       pr = $urandom_range(0, 999);
            1:       pr = $urandom_range(1000, 999999);
            2:       pr = $urandom_range(0, 20'hFFFFF);
            default: pr = $urandom_range(0, 99);
         endcase
         pt = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 0) pt = 6'd0;
         sg = 1'($urandom_range(0, 1));
         bus.price = pr[19:0];
         bus.point = pt;
         bus.sign  = sg;
         repeat (DWELL) tick;
         for (int s = 0; s < 6 * DWELL; s++) begin
            tick;
            k  = exp_digit(ecount);
            es = exp_sel(ecount);
            ec = exp_code(pr, pt, sg, k);
            checks++;
            if (bus.sel !== es || bus.seg !== ec) begin
               errors++;
               $display("FAIL random%0d_d%0d price=%0d point=%b sign=%b: sel=%h seg=%h expected sel=%h seg=%h",
                        it, k, pr, pt, sg, bus.sel, bus.seg, es, ec);
            end
         end
      end
   endtask

   task automatic test_enable;
      logic [5:0] es;
      logic [7:0] ec;
      bus.price = 20'd907;
      bus.point = 6'b000010;
      bus.sign  = 1'b1;
      repeat (DWELL + 20) tick;
      bus.seg_en = 1'b0;
      for (int s = 0; s < 40; s++) begin
         tick;
         checks++;
         if (bus.sel !== 6'h3F || bus.seg !== 8'hFF) begin
            errors++;
            $display("FAIL enable_off_%0d: sel=%h seg=%h expected sel=3f seg=ff", s, bus.sel, bus.seg);
         end
      end
      bus.seg_en = 1'b1;
      for (int s = 0; s < 120; s++) begin
         tick;
         es = exp_sel(ecount);
         ec = exp_code(907, 6'b000010, 1'b1, exp_digit(ecount));
         checks++;
         if (bus.sel !== es || bus.seg !== ec) begin
            errors++;
            $display("FAIL enable_resume_%0d: sel=%h seg=%h expected sel=%h seg=%h",
                     s, bus.sel, bus.seg, es, ec);
         end
      end
   endtask

   task automatic test_price_step;
      int unsigned guard;
      logic [7:0] ec;
      bus.price = 20'd100;
      bus.point = 6'd0;
      bus.sign  = 1'b0;
      repeat (DWELL) tick;
      guard = 0;
      while ((ecount - 1) % (6 * DWELL) != 2 * DWELL && guard < 400) begin
         tick;
         guard++;
      end
      checks++;
      if (guard >= 400) begin
         errors++;
         $display("FAIL step_align: ecount=%0d never reached digit 2 slot start", ecount);
      end
      ec = exp_code(100, 6'd0, 1'b0, 2);
      checks++;
      if (bus.sel !== 6'h3B || bus.seg !== ec) begin
         errors++;
         $display("FAIL step_before: sel=%h seg=%h expected sel=3b seg=%h", bus.sel, bus.seg, ec);
      end
      bus.price = 20'd200;
      repeat (45) tick;
      ec = exp_code(200, 6'd0, 1'b0, 2);
      checks++;
      if (bus.sel !== 6'h3B || bus.seg !== ec) begin
         errors++;
         $display("FAIL step_after_45: sel=%h seg=%h expected sel=3b seg=%h", bus.sel, bus.seg, ec);
      end
   endtask

   initial begin
      test_reset;
      test_patterns;
      test_random;
      test_enable;
      test_price_step;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
